// File: rtl/sdm_multi_mod_pkg.sv
// Shared definitions for the multi-channel sigma-delta modulator.
//   order_legal : accepts loop order 1 or 2 only
//   int_width   : integrator width for a given sample width (DW+3)
//   full_scale  : feedback magnitude FS = 2^(DW-1)
//   sat_add     : a + b clamped symmetrically to +/-(2^(iw-1)-1)
package sdm_pkg;

    function automatic bit order_legal(input int order);
        return (order == 1) || (order == 2);
    endfunction

    function automatic int int_width(input int dw);
        return dw + 3;
    endfunction

    function automatic logic signed [63:0] full_scale(input int dw);
        return 64'sd1 <<< (dw - 1);
    endfunction

    // The limit is symmetric so a saturated integrator never sits on the
    // one extra negative code that would make +FS/-FS feedback asymmetric.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int iw);
        logic signed [63:0] lim;
        logic signed [63:0] s;
        lim = (64'sd1 <<< (iw - 1)) - 64'sd1;
        s   = a + b;
        if (s > lim)
            return lim;
        else if (s < -lim)
            return -lim;
        return s;
    endfunction

endpackage

// File: rtl/sdm_multi_mod_if.sv
// Channel bus of the sigma-delta modulator.
//   EN, DIV, OSR, DVALID, DATA : configuration and sample stream (into the modulator)
//   DREADY, SDCLK, DSDOUT, UNDERRUN : handshake, modulator clock/bitstream, status
// master = sample source / controller, slave = modulator.
interface sdm_multi_mod_if #(
    parameter int CHANNELS = 2,
    parameter int DW       = 16,
    parameter int DIVW     = 8,
    parameter int OSRW     = 10
);
    logic [CHANNELS-1:0]      EN;
    logic [CHANNELS*DIVW-1:0] DIV;
    logic [OSRW-1:0]          OSR;
    logic [CHANNELS-1:0]      DVALID;
    logic [CHANNELS*DW-1:0]   DATA;
    logic [CHANNELS-1:0]      DREADY;
    logic [CHANNELS-1:0]      SDCLK;
    logic [CHANNELS-1:0]      DSDOUT;
    logic [CHANNELS-1:0]      UNDERRUN;

    modport master (
        output EN, DIV, OSR, DVALID, DATA,
        input  DREADY, SDCLK, DSDOUT, UNDERRUN
    );

    modport slave (
        input  EN, DIV, OSR, DVALID, DATA,
        output DREADY, SDCLK, DSDOUT, UNDERRUN
    );
endinterface

// File: rtl/sdm_multi_mod_channel.sv
// One sigma-delta modulator channel.
//   clk, rst : system clock, synchronous active-high reset
//   en       : channel enable (handshake keeps working while disabled)
//   div      : SDCLK half-period minus 1, picked up at each divider wrap
//   osr      : modulator steps per consumed sample (0 behaves as 1), picked up at each sample boundary
//   dvalid, data, dready : sample handshake into a one-deep holding register
//   sdclk, dsdout        : modulator clock and bitstream
//   underrun             : sticky, a sample was due and none was held
module sdm_channel
    import sdm_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ORDER = 2,
    parameter int DIVW  = 8,
    parameter int OSRW  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIVW-1:0]      div,
    input  logic [OSRW-1:0]      osr,
    input  logic                 dvalid,
    input  logic signed [DW-1:0] data,
    output logic                 dready,
    output logic                 sdclk,
    output logic                 dsdout,
    output logic                 underrun
);
    localparam int                 IW = int_width(DW);
    localparam logic signed [63:0] FS = full_scale(DW);

    if (!order_legal(ORDER)) begin : g_bad_order
        $error("sdm_channel: ORDER must be 1 or 2");
    end

    logic [DIVW-1:0]      div_cnt;
    logic [DIVW-1:0]      div_lat;
    logic [OSRW-1:0]      step_cnt;
    logic [OSRW-1:0]      osr_lat;
    logic signed [DW-1:0] hold;
    logic                 hold_full;
    logic signed [DW-1:0] x_cur;
    logic signed [IW-1:0] acc1;
    logic signed [IW-1:0] acc2;

    logic [OSRW-1:0]      osr_eff;
    logic                 tc;
    logic                 step;
    logic                 consume;
    logic                 xfer;
    logic signed [DW-1:0] x_eff;
    logic                 y;
    logic signed [63:0]   fb;
    logic signed [IW-1:0] acc1_nxt;
    logic signed [IW-1:0] acc2_nxt;

    always_comb begin
        osr_eff = (osr == '0) ? OSRW'(1) : osr;
        tc      = en && (div_cnt == div_lat);
        // falling SDCLK edge: bitstream then settles before the SDFM's rising-edge sample
        step    = tc && sdclk;
        consume = step && (step_cnt == '0);
        xfer    = dvalid && !hold_full;

        // on a consume step the fresh sample already feeds this step's arithmetic;
        // an empty register with a sample arriving bypasses straight into x
        x_eff = x_cur;
        if (consume) begin
            if (hold_full)
                x_eff = hold;
            else if (dvalid)
                x_eff = data;
        end

        y        = (ORDER == 1) ? !acc1[IW-1] : !acc2[IW-1];
        fb       = y ? FS : -FS;
        acc1_nxt = IW'(sat_add(64'(acc1), 64'(x_eff) - fb, IW));
        acc2_nxt = IW'(sat_add(64'(acc2), 64'(acc1_nxt) - fb, IW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            div_lat   <= div;
            sdclk     <= 1'b0;
            step_cnt  <= '0;
            osr_lat   <= OSRW'(1);
            hold      <= '0;
            hold_full <= 1'b0;
            x_cur     <= '0;
            acc1      <= '0;
            acc2      <= '0;
            dsdout    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (en) begin
                if (tc) begin
                    div_cnt <= '0;
                    div_lat <= div;
                    sdclk   <= ~sdclk;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            if (step) begin
                if (consume) begin
                    osr_lat  <= osr_eff;
                    step_cnt <= (osr_eff == OSRW'(1)) ? '0 : OSRW'(1);
                end else begin
                    step_cnt <= (step_cnt == osr_lat - OSRW'(1)) ? '0 : step_cnt + OSRW'(1);
                end
                acc1   <= acc1_nxt;
                if (ORDER == 2)
                    acc2 <= acc2_nxt;
                dsdout <= y;
            end

            x_cur <= x_eff;
            if (consume) begin
                if (hold_full)
                    hold_full <= 1'b0;
                else if (!dvalid)
                    underrun <= 1'b1;
            end else if (xfer) begin
                hold      <= data;
                hold_full <= 1'b1;
            end
        end
    end

    assign dready = !hold_full;

endmodule

// File: rtl/sdm_multi_mod.sv
// N-channel digital sigma-delta modulator, used as SDFM stimulus and as
// on-chip loopback source.
//   EXTCLK : system clock, all logic on the rising edge
//   EXTRST : synchronous active-high reset
//   sd_bus : per-channel enable, divider, shared OSR, sample handshake,
//            SDCLK/DSDOUT outputs and sticky UNDERRUN
module sdm_multi_mod
    import sdm_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DW       = 16,
    parameter int ORDER    = 2,
    parameter int DIVW     = 8,
    parameter int OSRW     = 10
) (
    input  logic            EXTCLK,
    input  logic            EXTRST,
    sdm_multi_mod_if.slave  sd_bus
);
    logic [CHANNELS-1:0] dready_w;
    logic [CHANNELS-1:0] sdclk_w;
    logic [CHANNELS-1:0] dsdout_w;
    logic [CHANNELS-1:0] underrun_w;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        sdm_channel #(
            .DW    (DW),
            .ORDER (ORDER),
            .DIVW  (DIVW),
            .OSRW  (OSRW)
        ) u_ch (
            .clk      (EXTCLK),
            .rst      (EXTRST),
            .en       (sd_bus.EN[k]),
            .div      (sd_bus.DIV[k*DIVW +: DIVW]),
            .osr      (sd_bus.OSR),
            .dvalid   (sd_bus.DVALID[k]),
            .data     (sd_bus.DATA[k*DW +: DW]),
            .dready   (dready_w[k]),
            .sdclk    (sdclk_w[k]),
            .dsdout   (dsdout_w[k]),
            .underrun (underrun_w[k])
        );
    end

    assign sd_bus.DREADY   = dready_w;
    assign sd_bus.SDCLK    = sdclk_w;
    assign sd_bus.DSDOUT   = dsdout_w;
    assign sd_bus.UNDERRUN = underrun_w;

endmodule

// File: tb/tb_sdm_multi_mod.sv
// Bench for sdm_multi_mod: an ORDER=1 and an ORDER=2 instance driven with
// identical stimulus, compared every cycle against a step-count based model.
module tb_sdm_multi_mod;

    logic        clk = 1'b0;
    logic        rst_v;
    logic [1:0]  en_v;
    logic [15:0] div_v;
    logic [9:0]  osr_v;
    logic [1:0]  dvalid_v;
    logic [31:0] data_v;

    always #5 clk = ~clk;

    sdm_multi_mod_if #(.CHANNELS(2), .DW(16), .DIVW(8), .OSRW(10)) if_o1 ();
    sdm_multi_mod_if #(.CHANNELS(2), .DW(16), .DIVW(8), .OSRW(10)) if_o2 ();

    assign if_o1.EN = en_v;  assign if_o1.DIV = div_v;  assign if_o1.OSR = osr_v;
    assign if_o1.DVALID = dvalid_v;  assign if_o1.DATA = data_v;
    assign if_o2.EN = en_v;  assign if_o2.DIV = div_v;  assign if_o2.OSR = osr_v;
    assign if_o2.DVALID = dvalid_v;  assign if_o2.DATA = data_v;

    sdm_multi_mod #(.CHANNELS(2), .DW(16), .ORDER(1), .DIVW(8), .OSRW(10)) dut_o1 (
        .EXTCLK(clk), .EXTRST(rst_v), .sd_bus(if_o1.slave));
    sdm_multi_mod #(.CHANNELS(2), .DW(16), .ORDER(2), .DIVW(8), .OSRW(10)) dut_o2 (
        .EXTCLK(clk), .EXTRST(rst_v), .sd_bus(if_o2.slave));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference model, indexed [order-1][channel]. Timing derives from the
    // number of enabled cycles since reset: the divider toggles SDCLK every
    // DIV+1 of them, a step is every second toggle, a sample is consumed on
    // steps 1, 1+OSR, 1+2*OSR, ...
    localparam longint FS  = 32768;
    localparam longint LIM = 262143;

    int     m_e     [2][2];
    bit     m_sdclk [2][2];
    bit     m_dsd   [2][2];
    bit     m_uf    [2][2];
    bit     m_step  [2][2];
    longint m_x     [2][2];
    longint m_acc1  [2][2];
    longint m_acc2  [2][2];
    longint m_hold  [2][2][$];

    function automatic longint sat(input longint v);
        if (v > LIM) return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    task automatic model_edge();
        for (int o = 0; o < 2; o++) begin
            for (int k = 0; k < 2; k++) begin
                int     d;
                int     osr;
                int     n;
                bit     cons;
                bit     y;
                longint din;
                longint fb;
                d    = int'(div_v[k*8 +: 8]);
                osr  = (osr_v == 0) ? 1 : int'(osr_v);
                din  = longint'($signed(data_v[k*16 +: 16]));
                cons = 1'b0;
                m_step[o][k] = 1'b0;
                if (rst_v) begin
                    m_e[o][k] = 0;  m_sdclk[o][k] = 0;  m_dsd[o][k] = 0;  m_uf[o][k] = 0;
                    m_x[o][k] = 0;  m_acc1[o][k] = 0;   m_acc2[o][k] = 0;
                    m_hold[o][k].delete();
                end else begin
                    if (en_v[k]) begin
                        m_e[o][k]++;
                        m_sdclk[o][k] = ((m_e[o][k] / (d + 1)) % 2) == 1;
                        if (m_e[o][k] % (2 * (d + 1)) == 0) begin
                            m_step[o][k] = 1'b1;
                            n = m_e[o][k] / (2 * (d + 1));
                            cons = ((n - 1) % osr) == 0;
                        end
                    end
                    if (cons) begin
                        if (m_hold[o][k].size() > 0)
                            m_x[o][k] = m_hold[o][k].pop_front();
                        else if (dvalid_v[k])
                            m_x[o][k] = din;
                        else
                            m_uf[o][k] = 1'b1;
                    end else if (dvalid_v[k] && m_hold[o][k].size() == 0) begin
                        m_hold[o][k].push_back(din);
                    end
                    if (m_step[o][k]) begin
                        y  = ((o == 0) ? m_acc1[o][k] : m_acc2[o][k]) >= 0;
                        fb = y ? FS : -FS;
                        m_acc1[o][k] = sat(m_acc1[o][k] + m_x[o][k] - fb);
                        if (o == 1)
                            m_acc2[o][k] = sat(m_acc2[o][k] + m_acc1[o][k] - fb);
                        m_dsd[o][k] = y;
                    end
                end
            end
        end
    endtask

    bit cap_en   = 0;
    bit ratio_en = 0;
    bit dens_en  = 0;
    bit cap_q[$];
    int falls [2];
    bit prev_sdclk [2];
    int dens_steps = 0;
    int dens_ones  = 0;

    task automatic compare();
        for (int o = 0; o < 2; o++) begin
            for (int k = 0; k < 2; k++) begin
                logic [3:0] ev;
                logic [3:0] gv;
                ev = {m_sdclk[o][k], m_dsd[o][k], m_hold[o][k].size() == 0, m_uf[o][k]};
                if (o == 0)
                    gv = {if_o1.SDCLK[k], if_o1.DSDOUT[k], if_o1.DREADY[k], if_o1.UNDERRUN[k]};
                else
                    gv = {if_o2.SDCLK[k], if_o2.DSDOUT[k], if_o2.DREADY[k], if_o2.UNDERRUN[k]};
                chk_eq($sformatf("ord%0d ch%0d {sdclk,dsd,rdy,unf}", o + 1, k), gv, ev);
            end
        end
        chk_eq("ord1 ch0 acc1", $signed(dut_o1.g_ch[0].u_ch.acc1), m_acc1[0][0]);
        chk_eq("ord1 ch1 acc1", $signed(dut_o1.g_ch[1].u_ch.acc1), m_acc1[0][1]);
        chk_eq("ord2 ch0 acc1", $signed(dut_o2.g_ch[0].u_ch.acc1), m_acc1[1][0]);
        chk_eq("ord2 ch0 acc2", $signed(dut_o2.g_ch[0].u_ch.acc2), m_acc2[1][0]);
        chk_eq("ord2 ch1 acc1", $signed(dut_o2.g_ch[1].u_ch.acc1), m_acc1[1][1]);
        chk_eq("ord2 ch1 acc2", $signed(dut_o2.g_ch[1].u_ch.acc2), m_acc2[1][1]);

        if (cap_en && m_step[0][0])
            cap_q.push_back(if_o1.DSDOUT[0]);
        for (int k = 0; k < 2; k++) begin
            if (ratio_en && prev_sdclk[k] && !if_o1.SDCLK[k])
                falls[k]++;
            prev_sdclk[k] = if_o1.SDCLK[k];
        end
        if (dens_en && m_step[1][0]) begin
            dens_steps++;
            dens_ones += int'(if_o2.DSDOUT[0]);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic check_1010(input string tag);
        bit seq [4];
        for (int i = 0; i < 4; i++)
            seq[i] = (i < cap_q.size()) ? cap_q[i] : 1'bx;
        chk_eq({tag, " step1"}, seq[0], 1);
        chk_eq({tag, " step2"}, seq[1], 0);
        chk_eq({tag, " step3"}, seq[2], 1);
        chk_eq({tag, " step4"}, seq[3], 0);
    endtask

    initial begin
        // zero sample, DIV=0, OSR=4, with a one-cycle reset mid-stream
        rst_v = 1; en_v = 2'b11; div_v = '0; osr_v = 10'd4; dvalid_v = 2'b11; data_v = '0;
        tick();
        rst_v = 0; cap_en = 1;
        repeat (100) tick();
        check_1010("zero sample");
        rst_v = 1; tick();
        rst_v = 0; cap_q.delete();
        repeat (40) tick();
        check_1010("after reset");
        cap_en = 0;

        // +half scale on ch0, -half scale on ch1
        rst_v = 1; data_v = {16'hC000, 16'h4000}; tick();
        rst_v = 0;
        repeat (200) tick();

        // ch0 DIV=3, ch1 DIV=0: step ratio 1:4
        rst_v = 1; div_v = {8'd0, 8'd3}; data_v = '0; tick();
        rst_v = 0; falls[0] = 0; falls[1] = 0; ratio_en = 1;
        repeat (400) tick();
        ratio_en = 0;
        chk_eq("ch0 steps in 400 cycles", falls[0], 50);
        chk_eq("ch1 vs ch0 step ratio", falls[1], 4 * falls[0]);

        // underrun: one sample, then starve, then isolated pulses
        rst_v = 1; div_v = '0; osr_v = 10'd4; dvalid_v = 2'b11; data_v = $urandom; tick();
        rst_v = 0; tick();
        dvalid_v = 2'b00;
        repeat (40) tick();
        chk_eq("underrun after starvation", if_o1.UNDERRUN, 2'b11);
        repeat (10) begin
            dvalid_v = 2'b11; data_v = $urandom; tick();
            dvalid_v = 2'b00;
            repeat (15) tick();
        end
        chk_eq("underrun sticky", if_o2.UNDERRUN, 2'b11);

        // randomized segments
        for (int s = 0; s < 8; s++) begin
            rst_v = 1;
            div_v = {8'($urandom_range(3)), 8'($urandom_range(3))};
            osr_v = 10'($urandom_range(5));
            tick();
            rst_v = 0;
            repeat (500) begin
                en_v     = {$urandom_range(7) != 0, $urandom_range(7) != 0};
                dvalid_v = 2'($urandom);
                data_v   = $urandom;
                rst_v    = ($urandom_range(199) == 0);
                tick();
            end
        end

        // near full scale, second order: saturation without wrap
        rst_v = 1; en_v = 2'b11; div_v = '0; osr_v = 10'd1; dvalid_v = 2'b11;
        data_v = {16'h7FFF, 16'h7FFF}; tick();
        rst_v = 0; dens_en = 1;
        repeat (40010) tick();
        dens_en = 0;
        chk_eq("ord2 ones density >= 0.999", (dens_steps >= 10000) && (dens_ones * 1000 >= dens_steps * 999), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
